// File: rtl/scpu_mem_responder_pkg.sv
// -----------------------------------------------------------------------------
// scpu_mem_responder_pkg
// Shared definitions for the serial-CPU memory responder and its RAM.
//   - Arbiter state encodings (HOLD/BOOT/RUN/STEAL).
//   - Default byte-address and data widths.
//   - Helper that tells whether a state hands the RAM port to the host.
// Optional feature macro used by the responder: SCPU_MEM_WRITE_PROTECT_EN
// (define it to suppress CPU writes below PROT_LIMIT and flag prot_err).
// -----------------------------------------------------------------------------
package scpu_mem_responder_pkg;

   localparam int SCPU_ADDR_W = 10;
   localparam int SCPU_DATA_W = 8;

   typedef enum logic [1:0] {
      ST_HOLD  = 2'd0,
      ST_BOOT  = 2'd1,
      ST_RUN   = 2'd2,
      ST_STEAL = 2'd3
   } scpu_mem_state_e;

   // The host owns the RAM port while the CPU is held or a cycle is stolen.
   function automatic logic is_host_slot(input scpu_mem_state_e st);
      return (st == ST_HOLD) || (st == ST_STEAL);
   endfunction

endpackage

// File: rtl/scpu_byte_ram.sv
// -----------------------------------------------------------------------------
// scpu_byte_ram
// Single-port synchronous RAM, 2^ADDR_W words of DATA_W bits.
// Ports:
//   clk   in   clock, rising edge
//   addr  in   word address
//   we    in   write enable; write lands at the clock edge
//   din   in   write data
//   dout  out  registered read data (1-cycle latency); a read of the address
//              being written returns the old contents
// Contents are not reset.
// -----------------------------------------------------------------------------
module scpu_byte_ram #(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic [ADDR_W-1:0] addr,
   input  logic              we,
   input  logic [DATA_W-1:0] din,
   output logic [DATA_W-1:0] dout
);

   localparam int DEPTH = 2 ** ADDR_W;

   logic [DATA_W-1:0] mem_r [0:DEPTH-1];
   logic [DATA_W-1:0] dout_r;

   // Storage write and registered read; the read samples pre-write contents.
   always_ff @(posedge clk) begin
      if (we) begin
         mem_r[addr] <= din;
      end
      dout_r <= mem_r[addr];
   end

   assign dout = dout_r;

endmodule

// File: rtl/scpu_mem_responder.sv
// -----------------------------------------------------------------------------
// scpu_mem_responder
// Memory-side responder for the serial 8-bit CPU bus. Owns a byte RAM, lets a
// host preload it while the CPU is held, issues the CPU start pulse after a
// boot request, and lets the host steal single cycles from a running CPU.
//
// Ports:
//   clk, rst                      clock / synchronous active-high reset
//   cpu_is_i_addr                 1 = instruction fetch, 0 = data access
//   cpu_i_addr, cpu_d_addr        CPU instruction / data byte address
//   cpu_d_we, cpu_dataout         CPU data write strobe / write data
//   cpu_i_datain, cpu_d_datain    fetched instruction / data byte (inactive = 0)
//   cpu_wait                      stalls the CPU (1 in reset, HOLD, BOOT, STEAL)
//   cpu_start                     one-cycle start pulse at end of BOOT
//   host_valid/ready/we/addr/wdata host request port
//   host_rdata, host_rvalid       host read data, valid one cycle after accept
//   host_boot                     level; rising edge in HOLD starts the boot
//   prot_err                      sticky CPU write-protect violation
//
// Optional feature: define SCPU_MEM_WRITE_PROTECT_EN to suppress CPU writes
// to addresses below PROT_LIMIT and raise prot_err; otherwise prot_err = 0.
// -----------------------------------------------------------------------------
module scpu_mem_responder
   import scpu_mem_responder_pkg::*;
#(
   parameter int ADDR_W     = SCPU_ADDR_W,
   parameter int DATA_W     = SCPU_DATA_W,
   parameter int BOOT_DLY   = 2,
   parameter int PROT_LIMIT = 64
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cpu_is_i_addr,
   input  logic [ADDR_W-1:0] cpu_i_addr,
   input  logic [ADDR_W-1:0] cpu_d_addr,
   input  logic              cpu_d_we,
   input  logic [DATA_W-1:0] cpu_dataout,
   output logic [DATA_W-1:0] cpu_i_datain,
   output logic [DATA_W-1:0] cpu_d_datain,
   output logic              cpu_wait,
   output logic              cpu_start,
   input  logic              host_valid,
   output logic              host_ready,
   input  logic              host_we,
   input  logic [ADDR_W-1:0] host_addr,
   input  logic [DATA_W-1:0] host_wdata,
   output logic [DATA_W-1:0] host_rdata,
   output logic              host_rvalid,
   input  logic              host_boot,
   output logic              prot_err
);

   // Elaboration-time parameter sanity.
   if (DATA_W != 8) begin : g_bad_data_w
      $error("scpu_mem_responder: DATA_W must be 8");
   end
   if (BOOT_DLY < 1 || BOOT_DLY > 15) begin : g_bad_boot_dly
      $error("scpu_mem_responder: BOOT_DLY must be 1..15");
   end
   if (PROT_LIMIT < 0 || PROT_LIMIT >= 2 ** ADDR_W) begin : g_bad_prot_limit
      $error("scpu_mem_responder: PROT_LIMIT out of address range");
   end

   localparam logic [3:0] BOOT_LAST = 4'(BOOT_DLY - 1);

   scpu_mem_state_e   state_r;
   scpu_mem_state_e   state_next_s;
   logic [3:0]        boot_cnt_r;
   logic              boot_prev_r;
   logic              boot_rise_s;
   logic              cpu_start_r;
   logic              cpu_wait_r;
   logic              host_rvalid_r;
   logic              host_acc_s;
   logic              cpu_slot_s;
   logic [ADDR_W-1:0] cpu_addr_s;
   logic              cpu_wr_req_s;
   logic              prot_hit_s;
   logic [ADDR_W-1:0] ram_addr_s;
   logic              ram_we_s;
   logic [DATA_W-1:0] ram_din_s;
   logic [DATA_W-1:0] ram_dout_s;
   logic              cpu_acc_r;
   logic              cpu_is_i_r;
   logic [DATA_W-1:0] cpu_hold_r;
   logic [DATA_W-1:0] cpu_data_s;

   assign boot_rise_s  = host_boot & ~boot_prev_r;
   assign host_acc_s   = host_valid & is_host_slot(state_r);
   assign cpu_slot_s   = (state_r == ST_RUN);
   assign cpu_addr_s   = cpu_is_i_addr ? cpu_i_addr : cpu_d_addr;
   assign cpu_wr_req_s = cpu_slot_s & cpu_d_we & ~cpu_is_i_addr;

`ifdef SCPU_MEM_WRITE_PROTECT_EN
   localparam logic [ADDR_W-1:0] PROT_LIMIT_A = ADDR_W'(PROT_LIMIT);
   logic prot_err_r;

   assign prot_hit_s = cpu_wr_req_s & (cpu_d_addr < PROT_LIMIT_A);

   // Sticky violation flag, cleared only by reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         prot_err_r <= 1'b0;
      end else begin
         prot_err_r <= prot_err_r | prot_hit_s;
      end
   end

   assign prot_err = prot_err_r;
`else
   assign prot_hit_s = 1'b0;
   assign prot_err   = 1'b0;
`endif

   // Arbiter next-state: boot edge leaves HOLD, host requests steal from RUN.
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         ST_HOLD: begin
            if (boot_rise_s) state_next_s = ST_BOOT;
            else             state_next_s = ST_HOLD;
         end
         ST_BOOT: begin
            if (boot_cnt_r == BOOT_LAST) state_next_s = ST_RUN;
            else                         state_next_s = ST_BOOT;
         end
         ST_RUN: begin
            if (host_valid) state_next_s = ST_STEAL;
            else            state_next_s = ST_RUN;
         end
         ST_STEAL: state_next_s = ST_RUN;
         default:  state_next_s = ST_HOLD;
      endcase
   end

   // RAM port mux: host in HOLD/STEAL, CPU in RUN, idle in BOOT.
   always_comb begin
      ram_addr_s = host_addr;
      ram_we_s   = 1'b0;
      ram_din_s  = host_wdata;
      if (host_acc_s) begin
         ram_addr_s = host_addr;
         ram_we_s   = host_we;
         ram_din_s  = host_wdata;
      end else if (cpu_slot_s) begin
         ram_addr_s = cpu_addr_s;
         ram_we_s   = cpu_wr_req_s & ~prot_hit_s;
         ram_din_s  = cpu_dataout;
      end else begin
         ram_addr_s = host_addr;
         ram_we_s   = 1'b0;
         ram_din_s  = host_wdata;
      end
   end

   scpu_byte_ram #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_ram (
      .clk  (clk),
      .addr (ram_addr_s),
      .we   (ram_we_s),
      .din  (ram_din_s),
      .dout (ram_dout_s)
   );

   // Arbiter state, boot counter and host_boot edge history.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= ST_HOLD;
         boot_cnt_r  <= 4'd0;
         // Track the live level so a boot held high through reset is not an edge.
         boot_prev_r <= host_boot;
      end else begin
         state_r     <= state_next_s;
         boot_prev_r <= host_boot;
         if (state_r == ST_BOOT && state_next_s == ST_BOOT) begin
            boot_cnt_r <= boot_cnt_r + 4'd1;
         end else begin
            boot_cnt_r <= 4'd0;
         end
      end
   end

   // Registered CPU control outputs and host read-valid.
   always_ff @(posedge clk) begin
      if (rst) begin
         cpu_start_r   <= 1'b0;
         cpu_wait_r    <= 1'b1;
         host_rvalid_r <= 1'b0;
      end else begin
         cpu_start_r   <= (state_r == ST_BOOT) && (state_next_s == ST_RUN);
         cpu_wait_r    <= (state_next_s != ST_RUN);
         host_rvalid_r <= host_acc_s & ~host_we;
      end
   end

   // CPU read steering: remember which bus the last CPU access used and hold
   // the presented byte across cycles the CPU did not own the port.
   always_ff @(posedge clk) begin
      if (rst) begin
         cpu_acc_r  <= 1'b0;
         cpu_is_i_r <= 1'b0;
         cpu_hold_r <= {DATA_W{1'b0}};
      end else begin
         cpu_acc_r  <= cpu_slot_s;
         if (cpu_slot_s) begin
            cpu_is_i_r <= cpu_is_i_addr;
         end
         cpu_hold_r <= cpu_data_s;
      end
   end

   assign cpu_data_s   = cpu_acc_r ? ram_dout_s : cpu_hold_r;
   assign cpu_i_datain = cpu_is_i_r ? cpu_data_s : {DATA_W{1'b0}};
   assign cpu_d_datain = cpu_is_i_r ? {DATA_W{1'b0}} : cpu_data_s;
   assign host_rdata   = host_rvalid_r ? ram_dout_s : {DATA_W{1'b0}};
   assign host_rvalid  = host_rvalid_r;
   assign host_ready   = host_acc_s;
   assign cpu_wait     = cpu_wait_r;
   assign cpu_start    = cpu_start_r;

endmodule

// File: tb/tb_scpu_mem_responder.sv
// Directed bench for scpu_mem_responder (ADDR_W=10, BOOT_DLY=2, PROT_LIMIT=64).
module tb_scpu_mem_responder;

   logic       clk = 1'b0;
   logic       rst;
   logic       cpu_is_i_addr;
   logic [9:0] cpu_i_addr;
   logic [9:0] cpu_d_addr;
   logic       cpu_d_we;
   logic [7:0] cpu_dataout;
   logic [7:0] cpu_i_datain;
   logic [7:0] cpu_d_datain;
   logic       cpu_wait;
   logic       cpu_start;
   logic       host_valid;
   logic       host_ready;
   logic       host_we;
   logic [9:0] host_addr;
   logic [7:0] host_wdata;
   logic [7:0] host_rdata;
   logic       host_rvalid;
   logic       host_boot;
   logic       prot_err;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   scpu_mem_responder #(
      .ADDR_W(10), .DATA_W(8), .BOOT_DLY(2), .PROT_LIMIT(64)
   ) dut (
      .clk(clk), .rst(rst),
      .cpu_is_i_addr(cpu_is_i_addr), .cpu_i_addr(cpu_i_addr), .cpu_d_addr(cpu_d_addr),
      .cpu_d_we(cpu_d_we), .cpu_dataout(cpu_dataout),
      .cpu_i_datain(cpu_i_datain), .cpu_d_datain(cpu_d_datain),
      .cpu_wait(cpu_wait), .cpu_start(cpu_start),
      .host_valid(host_valid), .host_ready(host_ready), .host_we(host_we),
      .host_addr(host_addr), .host_wdata(host_wdata),
      .host_rdata(host_rdata), .host_rvalid(host_rvalid),
      .host_boot(host_boot), .prot_err(prot_err)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; host_valid = 1'b0; host_we = 1'b0; host_addr = 10'd0; host_wdata = 8'h00;
      host_boot = 1'b0; cpu_is_i_addr = 1'b0; cpu_i_addr = 10'd0; cpu_d_addr = 10'd0;
      cpu_d_we = 1'b0; cpu_dataout = 8'h00;
      tick(); tick();
      n_cmp++; if (cpu_wait !== 1'b1) begin n_bad++; $display("FAIL rst_wait got %b exp 1", cpu_wait); end
      n_cmp++; if (cpu_start !== 1'b0) begin n_bad++; $display("FAIL rst_start got %b exp 0", cpu_start); end
      n_cmp++; if (host_rvalid !== 1'b0) begin n_bad++; $display("FAIL rst_rvalid got %b exp 0", host_rvalid); end
      n_cmp++; if (host_rdata !== 8'h00) begin n_bad++; $display("FAIL rst_rdata got %h exp 00", host_rdata); end
      n_cmp++; if (cpu_i_datain !== 8'h00) begin n_bad++; $display("FAIL rst_idata got %h exp 00", cpu_i_datain); end
      n_cmp++; if (cpu_d_datain !== 8'h00) begin n_bad++; $display("FAIL rst_ddata got %h exp 00", cpu_d_datain); end
      n_cmp++; if (prot_err !== 1'b0) begin n_bad++; $display("FAIL rst_prot got %b exp 0", prot_err); end
      n_cmp++; if (host_ready !== 1'b0) begin n_bad++; $display("FAIL rst_ready got %b exp 0", host_ready); end
      rst = 1'b0;
   endtask

   task automatic test_host_load();
      logic [9:0] addrs [4] = '{10'd32, 10'd33, 10'd4, 10'd5};
      logic [7:0] datas [4] = '{8'h10, 8'h11, 8'h44, 8'h55};
      for (int i = 0; i < 4; i++) begin
         host_valid = 1'b1; host_we = 1'b1; host_addr = addrs[i]; host_wdata = datas[i];
         #1;
         n_cmp++; if (host_ready !== 1'b1) begin n_bad++; $display("FAIL load_ready[%0d] got %b exp 1", i, host_ready); end
         tick();
         n_cmp++; if (cpu_wait !== 1'b1) begin n_bad++; $display("FAIL load_wait[%0d] got %b exp 1", i, cpu_wait); end
      end
      host_we = 1'b0; host_addr = 10'd33;
      #1;
      n_cmp++; if (host_ready !== 1'b1) begin n_bad++; $display("FAIL load_rd_ready got %b exp 1", host_ready); end
      tick();
      host_valid = 1'b0;
      n_cmp++; if (host_rvalid !== 1'b1) begin n_bad++; $display("FAIL load_rvalid got %b exp 1", host_rvalid); end
      n_cmp++; if (host_rdata !== 8'h11) begin n_bad++; $display("FAIL load_rdata got %h exp 11", host_rdata); end
      n_cmp++; if (cpu_wait !== 1'b1) begin n_bad++; $display("FAIL load_rd_wait got %b exp 1", cpu_wait); end
      tick();
      n_cmp++; if (host_rvalid !== 1'b0) begin n_bad++; $display("FAIL load_rvalid_drop got %b exp 0", host_rvalid); end
   endtask

   task automatic test_boot();
      host_boot = 1'b1;
      tick();
      n_cmp++; if (cpu_start !== 1'b0 || cpu_wait !== 1'b1) begin n_bad++; $display("FAIL boot_c1 got start=%b wait=%b exp 0/1", cpu_start, cpu_wait); end
      host_valid = 1'b1; host_we = 1'b0; host_addr = 10'd32;
      #1;
      n_cmp++; if (host_ready !== 1'b0) begin n_bad++; $display("FAIL boot_blocked got %b exp 0", host_ready); end
      tick();
      host_valid = 1'b0;
      n_cmp++; if (cpu_start !== 1'b0 || cpu_wait !== 1'b1) begin n_bad++; $display("FAIL boot_c2 got start=%b wait=%b exp 0/1", cpu_start, cpu_wait); end
      n_cmp++; if (host_rvalid !== 1'b0) begin n_bad++; $display("FAIL boot_no_rvalid got %b exp 0", host_rvalid); end
      tick();
      n_cmp++; if (cpu_start !== 1'b1 || cpu_wait !== 1'b0) begin n_bad++; $display("FAIL boot_c3 got start=%b wait=%b exp 1/0", cpu_start, cpu_wait); end
      tick();
      n_cmp++; if (cpu_start !== 1'b0 || cpu_wait !== 1'b0) begin n_bad++; $display("FAIL boot_c4 got start=%b wait=%b exp 0/0", cpu_start, cpu_wait); end
      host_boot = 1'b0;
      tick();
      host_boot = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         n_cmp++; if (cpu_start !== 1'b0 || cpu_wait !== 1'b0) begin n_bad++; $display("FAIL reboot_run[%0d] got start=%b wait=%b exp 0/0", i, cpu_start, cpu_wait); end
      end
      host_boot = 1'b0;
   endtask

   task automatic test_cpu_access();
      cpu_is_i_addr = 1'b1; cpu_i_addr = 10'd32;
      tick();
      n_cmp++; if (cpu_i_datain !== 8'h10) begin n_bad++; $display("FAIL ifetch got %h exp 10", cpu_i_datain); end
      n_cmp++; if (cpu_d_datain !== 8'h00) begin n_bad++; $display("FAIL ifetch_d0 got %h exp 00", cpu_d_datain); end
      cpu_is_i_addr = 1'b0; cpu_d_addr = 10'd4; cpu_d_we = 1'b1; cpu_dataout = 8'h0A;
      tick();
      n_cmp++; if (cpu_d_datain !== 8'h44) begin n_bad++; $display("FAIL dwrite_old got %h exp 44", cpu_d_datain); end
      n_cmp++; if (cpu_i_datain !== 8'h00) begin n_bad++; $display("FAIL dwrite_i0 got %h exp 00", cpu_i_datain); end
      cpu_d_we = 1'b0;
      tick();
      n_cmp++; if (cpu_d_datain !== 8'h0A) begin n_bad++; $display("FAIL dread got %h exp 0a", cpu_d_datain); end
      // d_we must be ignored on an instruction fetch
      cpu_is_i_addr = 1'b1; cpu_d_we = 1'b1; cpu_d_addr = 10'd33; cpu_dataout = 8'hEE;
      tick();
      cpu_is_i_addr = 1'b0; cpu_d_we = 1'b0;
      tick();
      n_cmp++; if (cpu_d_datain !== 8'h11) begin n_bad++; $display("FAIL ifetch_we_ignored got %h exp 11", cpu_d_datain); end
   endtask

   task automatic test_steal();
      logic       exp_wait [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
      logic [7:0] exp_i    [4] = '{8'h10, 8'h10, 8'h11, 8'h11};
      logic [9:0] cpu_nx   [4] = '{10'd33, 10'd33, 10'd32, 10'd32};
      logic [9:0] host_nx  [4] = '{10'd4, 10'd33, 10'd33, 10'd33};
      cpu_is_i_addr = 1'b1; cpu_i_addr = 10'd32;
      host_valid = 1'b1; host_we = 1'b0; host_addr = 10'd4;
      #1;
      n_cmp++; if (host_ready !== 1'b0) begin n_bad++; $display("FAIL steal_run_ready got %b exp 0", host_ready); end
      for (int i = 0; i < 4; i++) begin
         tick();
         n_cmp++; if (cpu_wait !== exp_wait[i]) begin n_bad++; $display("FAIL steal_wait[%0d] got %b exp %b", i, cpu_wait, exp_wait[i]); end
         n_cmp++; if (host_ready !== exp_wait[i]) begin n_bad++; $display("FAIL steal_ready[%0d] got %b exp %b", i, host_ready, exp_wait[i]); end
         n_cmp++; if (cpu_i_datain !== exp_i[i]) begin n_bad++; $display("FAIL steal_idata[%0d] got %h exp %h", i, cpu_i_datain, exp_i[i]); end
         if (i == 1) begin
            n_cmp++; if (host_rvalid !== 1'b1 || host_rdata !== 8'h0A) begin n_bad++; $display("FAIL steal_rd1 got v=%b d=%h exp 1/0a", host_rvalid, host_rdata); end
         end else if (i == 3) begin
            n_cmp++; if (host_rvalid !== 1'b1 || host_rdata !== 8'h11) begin n_bad++; $display("FAIL steal_rd2 got v=%b d=%h exp 1/11", host_rvalid, host_rdata); end
         end else begin
            n_cmp++; if (host_rvalid !== 1'b0) begin n_bad++; $display("FAIL steal_rvalid[%0d] got %b exp 0", i, host_rvalid); end
         end
         cpu_i_addr = cpu_nx[i]; host_addr = host_nx[i];
      end
      host_valid = 1'b0;
   endtask

   task automatic test_protect();
      cpu_is_i_addr = 1'b0; cpu_d_addr = 10'd5; cpu_d_we = 1'b1; cpu_dataout = 8'hFF;
      tick();
      cpu_d_we = 1'b0;
`ifdef SCPU_MEM_WRITE_PROTECT_EN
      n_cmp++; if (prot_err !== 1'b1) begin n_bad++; $display("FAIL prot_set got %b exp 1", prot_err); end
`else
      n_cmp++; if (prot_err !== 1'b0) begin n_bad++; $display("FAIL prot_tied got %b exp 0", prot_err); end
`endif
      tick();
`ifdef SCPU_MEM_WRITE_PROTECT_EN
      n_cmp++; if (cpu_d_datain !== 8'h55) begin n_bad++; $display("FAIL prot_ram5 got %h exp 55", cpu_d_datain); end
`else
      n_cmp++; if (cpu_d_datain !== 8'hFF) begin n_bad++; $display("FAIL noprot_ram5 got %h exp ff", cpu_d_datain); end
`endif
      cpu_d_addr = 10'd64; cpu_d_we = 1'b1; cpu_dataout = 8'h64;
      tick();
      cpu_d_we = 1'b0;
      tick();
      n_cmp++; if (cpu_d_datain !== 8'h64) begin n_bad++; $display("FAIL ram64 got %h exp 64", cpu_d_datain); end
`ifdef SCPU_MEM_WRITE_PROTECT_EN
      n_cmp++; if (prot_err !== 1'b1) begin n_bad++; $display("FAIL prot_sticky got %b exp 1", prot_err); end
`else
      n_cmp++; if (prot_err !== 1'b0) begin n_bad++; $display("FAIL prot_tied2 got %b exp 0", prot_err); end
`endif
   endtask

   task automatic test_reset_mid_boot();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      host_boot = 1'b1;
      tick();
      host_valid = 1'b1; host_we = 1'b0; host_addr = 10'd32;
      #1;
      n_cmp++; if (host_ready !== 1'b0) begin n_bad++; $display("FAIL mid_in_boot got %b exp 0", host_ready); end
      rst = 1'b1;
      tick();
      n_cmp++; if (cpu_start !== 1'b0 || cpu_wait !== 1'b1) begin n_bad++; $display("FAIL mid_rst got start=%b wait=%b exp 0/1", cpu_start, cpu_wait); end
      n_cmp++; if (host_ready !== 1'b1) begin n_bad++; $display("FAIL mid_hold got ready=%b exp 1", host_ready); end
      tick();
      n_cmp++; if (host_rvalid !== 1'b0) begin n_bad++; $display("FAIL mid_rvalid_drop got %b exp 0", host_rvalid); end
      rst = 1'b0; host_valid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         n_cmp++; if (cpu_start !== 1'b0 || cpu_wait !== 1'b1) begin n_bad++; $display("FAIL mid_after[%0d] got start=%b wait=%b exp 0/1", i, cpu_start, cpu_wait); end
      end
      host_boot = 1'b0;
   endtask

   initial begin
      test_reset();
      test_host_load();
      test_boot();
      test_cpu_access();
      test_steal();
      test_protect();
      test_reset_mid_boot();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/scpu_mem_responder.md
Name: scpu_mem_responder

Overview:
- Memory-side responder for the serial 8-bit CPU bus: owns a byte-wide 2^ADDR_W x 8 RAM and answers the CPU's multiplexed instruction/data fetches and data writes.
- Adds a host port that preloads program and data bytes, then issues the CPU start pulse.
- The host can also steal single cycles from a running CPU by asserting cpu_wait.
- Replaces testbench back-door RAM writes with a synthesizable boot path.

Parameters:
- ADDR_W, 10, byte address width; RAM depth 2^ADDR_W.
- DATA_W, 8, byte width; fixed at 8 (checked at elaboration).
- BOOT_DLY, 2, cycles between boot request and start pulse (range 1..15).
- PROT_LIMIT, 64, first byte address the CPU may write when the write-protect feature is compiled in.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- cpu_is_i_addr  in  1  1 = instruction fetch (use cpu_i_addr), 0 = data access (use cpu_d_addr).
- cpu_i_addr  in  ADDR_W  instruction byte address.
- cpu_d_addr  in  ADDR_W  data byte address.
- cpu_d_we  in  1  CPU data write strobe; ignored when cpu_is_i_addr=1.
- cpu_dataout  in  8  CPU write data.
- cpu_i_datain  out  8  fetched instruction byte; 0 when the last access was data.
- cpu_d_datain  out  8  read data byte; 0 when the last access was instruction.
- cpu_wait  out  1  stalls the CPU.
- cpu_start  out  1  one-cycle start pulse.
- host_valid  in  1  host request.
- host_ready  out  1  request accepted this cycle.
- host_we  in  1  1 = write, 0 = read.
- host_addr  in  ADDR_W  host byte address.
- host_wdata  in  8  host write data.
- host_rdata  out  8  host read data.
- host_rvalid  out  1  host_rdata valid for one cycle.
- host_boot  in  1  level; rising edge requests a CPU start.
- prot_err  out  1  sticky write-protect violation; meaningful only with the feature.

Behaviour:
- Reset values:
  - All outputs 0 except cpu_wait=1.
  - FSM enters HOLD; the boot counter clears.
  - RAM contents are not cleared.
- RAM access:
  - Single port, one access per cycle.
  - Reads are registered with 1-cycle latency.
  - Writes take effect at the clock edge.
  - Read-during-write to the same address returns the old byte.
- FSM states:
  - HOLD: cpu_wait=1. Host served every cycle (host_ready = host_valid). A host_boot rising edge goes to BOOT.
  - BOOT: counts BOOT_DLY cycles with cpu_wait=1 and the host blocked (host_ready=0). Then drives cpu_start=1 for exactly 1 cycle, drops cpu_wait, and goes to RUN.
  - RUN: the CPU owns the port. Address = cpu_is_i_addr ? cpu_i_addr : cpu_d_addr. Write happens when cpu_d_we & ~cpu_is_i_addr.
  - RUN + host_valid: go to STEAL.
  - STEAL: cpu_wait=1 for exactly 1 cycle. host_ready=1 and the host access uses the port in that cycle. CPU port inputs are ignored. Return to RUN. host_valid held high yields alternate RUN/STEAL cycles, which guarantees CPU progress.
  - host_boot rising edge in RUN: ignored.
  - host_boot falling edge: no effect in any state.
- Return to HOLD: from any state on rst only. cpu_wait behaves as a pause, not a reset.
- Output steering:
  - cpu_i_datain / cpu_d_datain follow the registered cpu_is_i_addr of the access that produced the data, so the inactive bus reads 0.
  - Data from a STEAL cycle goes only to host_rdata (host_rvalid=1 next cycle); the CPU outputs hold their previous value.
- Host writes to any address are always allowed.
- Reset mid-operation: a pending host_rvalid is dropped, and a start pulse not yet issued is cancelled.
- Addresses wrap naturally at 2^ADDR_W; there is no range error.

Optional Feature:
- Macro: SCPU_MEM_WRITE_PROTECT_EN.
- Defined:
  - CPU writes with address < PROT_LIMIT are suppressed (RAM unchanged).
  - prot_err sets to 1 on the following cycle and stays set until rst.
  - Host writes are unaffected.
- Undefined: no suppression; prot_err is tied to 0.

Decomposition:
- Shared package/include (alongside the CPU define file):
  - FSM state encodings HOLD=2'd0, BOOT=2'd1, RUN=2'd2, STEAL=2'd3.
  - Default ADDR_W.
  - Macro name SCPU_MEM_WRITE_PROTECT_EN.
- One sub-module, scpu_byte_ram: single-port synchronous RAM with registered read (addr, we, din, dout).
- Arbiter FSM, boot counter and steering stay in the top module.

Test Plan:
- Reset, then host writes 0x10 to addr 32 and 0x11 to addr 33, then reads 33 -> host_ready=1 each cycle; host_rvalid with rdata=0x11 one cycle after the read; cpu_wait=1 throughout.
- host_boot rises with BOOT_DLY=2 -> cpu_start high exactly 1 cycle, 3 cycles after the edge; cpu_wait falls in the same cycle; second edge in RUN gives no pulse.
- RUN, cpu_is_i_addr=1, i_addr=32 (RAM 0x10) -> cpu_i_datain=0x10 next cycle, cpu_d_datain=0; data write d_addr=4 data 0x0A, then read -> cpu_d_datain=0x0A.
- RUN with host_valid held 4 cycles -> cpu_wait pattern 1,0,1,0; host_ready aligned to the 1s; CPU outputs unchanged in stolen cycles.
- With SCPU_MEM_WRITE_PROTECT_EN, PROT_LIMIT=64: CPU write 0xFF to addr 5 -> RAM[5] unchanged, prot_err=1 and sticky; write to 64 succeeds. Without macro: RAM[5]=0xFF, prot_err=0.
- rst asserted during BOOT count -> no cpu_start, state HOLD, cpu_wait=1, host_rvalid=0.
